nibble_tx: RTL and testbench
============================

NIBBLE_TX -- requirements
Module: nibble_tx

Interface
REQ-001 Parameter NIBBLES, default 8: the number of 4-bit segments per word; the word width is 4*NIBBLES.
REQ-002 Parameter TIMEOUT, default 255: the maximum number of cycles to wait in any handshake phase; a value of 0 disables the timeout.
REQ-003 clk  input  1  The clock is clk, and all state changes on its rising edge.
REQ-004 rst_n  input  1  The reset is rst_n: synchronous, active-low.
REQ-005 in_valid  input  1  Indicates the upstream word is valid.
REQ-006 in_ready  output  1  Indicates the block can accept a word.
REQ-007 in_data  input  4*NIBBLES  The word to transmit.
REQ-008 tx_send  output  1  The send strobe to the remote receiver.
REQ-009 tx_nib  output  4  The current nibble.
REQ-010 tx_ack  input  1  The receiver acknowledge; it is asynchronous to clk.
REQ-011 busy  output  1  Indicates a word is in transfer.
REQ-012 done  output  1  A one-cycle pulse marking successful completion of a word.
REQ-013 timeout_err  output  1  A one-cycle pulse marking an aborted word.

Function
REQ-014 tx_ack shall pass through a 2-flop synchronizer before use (ack_s); the FSM shall use only ack_s.
REQ-015 The FSM shall have the states IDLE, DRIVE, RELEASE and FINISH.
REQ-016 In IDLE:
- in_ready shall be 1, and in all other states in_ready shall be 0.
- When in_valid and in_ready are both 1, the block shall latch in_data into a shift register, clear the nibble index to 0 and enter DRIVE.
REQ-017 On entry to DRIVE, tx_nib shall be loaded with nibble[index] (bits 4*i+3:4*i, least-significant nibble first) and tx_send shall be 1.
REQ-018 tx_send and tx_nib shall be registered outputs.
- tx_send shall rise in the same cycle tx_nib updates.
- tx_nib shall stay stable through both DRIVE and RELEASE for that nibble.
REQ-019 In DRIVE, when ack_s = 1, the block shall enter RELEASE; tx_send shall be 0 from the next cycle.
REQ-020 In RELEASE, when ack_s = 0:
- If index < NIBBLES-1, the block shall increment index and enter DRIVE with the next nibble.
- Otherwise the block shall enter FINISH.
REQ-021 FINISH shall last exactly one cycle: done = 1, then the block returns to IDLE.
REQ-022 busy shall be 1 in DRIVE, RELEASE and FINISH.
REQ-023 A timeout counter shall clear on every entry to DRIVE or RELEASE and increment each cycle spent in those states.
REQ-024 With TIMEOUT ≠ 0, if the counter reaches TIMEOUT while the awaited ack_s level is absent:
- The block shall go to IDLE with tx_send = 0.
- timeout_err shall pulse for one cycle.
- done shall not assert.
REQ-025 After a timeout, the partially sent word shall be discarded and not retried.
REQ-026 An ack_s level that is already satisfied on phase entry shall advance the FSM after one cycle in that phase, never in zero cycles.
REQ-027 in_data and in_valid shall be ignored outside IDLE; a new word shall be accepted no earlier than the cycle after FINISH.
REQ-028 done and timeout_err shall never assert in the same cycle.
REQ-029 The timeout counter width shall be sufficient to hold TIMEOUT and shall not wrap before reaching it.

Reset
REQ-030 While rst_n = 0 at a clock edge, the outputs shall take these values: state IDLE, tx_send = 0, tx_nib = 0, in_ready = 1, busy = 0, done = 0, timeout_err = 0, index = 0, counter = 0, synchronizer flops = 0.
REQ-031 Reset asserted mid-transfer shall abort the word immediately: no done, no timeout_err, and tx_send = 0 on the next cycle.

Verification
REQ-032 Basic transfer: send word 0x1234ABCD with an ideal receiver model (ack follows send after 1 cycle).
- tx_nib sequence shall be D,C,B,A,4,3,2,1.
- There shall be 8 send/ack four-phase cycles.
- done shall pulse exactly once, and in_ready shall return to 1.
REQ-033 Back-to-back words: hold in_valid = 1 with 0xFFFFFFFF then 0x00000000.
- The second word shall be accepted only in the IDLE cycle after FINISH.
- The nibble stream shall be F×8 then 0×8.
REQ-034 Timeout: run with TIMEOUT = 10 and the receiver never acknowledging nibble 2.
- timeout_err shall pulse once, 10 cycles after DRIVE entry.
- tx_send shall be 0 and the block in IDLE afterwards.
- done shall never assert.
REQ-035 Stuck-high ack: hold tx_ack = 1 through the end of nibble 0 (timeout at the RELEASE phase).
- The block shall abort with timeout_err.
- The next word shall transmit normally after tx_ack is released.
REQ-036 Reset mid-word: assert rst_n = 0 during nibble 4.
- All outputs shall match their REQ-030 values the following cycle.
- A fresh word 0x00000005 shall then send nibbles 5,0,0,0,0,0,0,0.
REQ-037 Parameter sweep: set NIBBLES = 2 and send 0xA5.
- The sequence shall be 5,A, and done shall pulse after the second four-phase cycle.

Source files
------------

// File: rtl/nibble_tx_if.sv
// Word-in / nibble-out handshake bundle for nibble_tx.
// The slave view is the transmitter itself; the master view is whoever
// supplies words and plays the remote receiver.
interface nibble_tx_if #(
  parameter int NIBBLES = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NIBBLES-1:0]   in_data;
  logic                   tx_send;
  logic [3:0]             tx_nib;
  logic                   tx_ack;
  logic                   busy;
  logic                   done;
  logic                   timeout_err;

  modport slave (
    input  in_valid, in_data, tx_ack,
    output in_ready, tx_send, tx_nib, busy, done, timeout_err
  );

  modport master (
    output in_valid, in_data, tx_ack,
    input  in_ready, tx_send, tx_nib, busy, done, timeout_err
  );
endinterface

// File: rtl/nibble_tx.sv
// Nibble-serial transmitter: takes a 4*NIBBLES-bit word and sends it LSB
// nibble first over a four-phase send/ack handshake with an asynchronous
// receiver. Each handshake phase is guarded by an optional timeout.
module nibble_tx #(
  parameter int NIBBLES = 8,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  nibble_tx_if.slave bus
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit            TO_EN    = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RELEASE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic            sync1_r;
  logic            ack_s;
  logic [W-1:0]    shift_r;
  logic [W-1:0]    shifted_s;
  logic [IW-1:0]   idx_r;
  logic [CW-1:0]   cnt_r;
  logic            tx_send_r;
  logic [3:0]      tx_nib_r;
  logic            timeout_err_r;
  logic            to_hit_s;
  logic            timeout_s;
  logic            in_ready_s;
  logic            busy_s;
  logic            done_s;

  assign shifted_s = shift_r >> 3'd4;
  // The counter holds the number of cycles already spent in the phase, so
  // it equals TIMEOUT-1 on the TIMEOUT-th cycle of waiting.
  assign to_hit_s  = TO_EN && (cnt_r == TO_LAST);

  // Bring the asynchronous acknowledge into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      ack_s   <= 1'b0;
    end else begin
      sync1_r <= bus.tx_ack;
      ack_s   <= sync1_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; the awaited ack level wins over a same-cycle timeout.
  always_comb begin
    next_state_s = state_r;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          next_state_s = DRIVE;
        end else begin
          next_state_s = IDLE;
        end
      end
      DRIVE: begin
        if (ack_s) begin
          next_state_s = RELEASE;
        end else if (to_hit_s) begin
          next_state_s = IDLE;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = DRIVE;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          if (idx_r == LAST_IDX) begin
            next_state_s = FINISH;
          end else begin
            next_state_s = DRIVE;
          end
        end else if (to_hit_s) begin
          next_state_s = IDLE;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = RELEASE;
        end
      end
      FINISH: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM output decode from the registered state.
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
      end
      DRIVE, RELEASE: begin
        busy_s = 1'b1;
      end
      FINISH: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // Word shifter, nibble index, phase timer and registered line outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_r       <= '0;
      idx_r         <= '0;
      cnt_r         <= '0;
      tx_send_r     <= 1'b0;
      tx_nib_r      <= 4'h0;
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= timeout_s;
      // tx_send is the registered image of "next state is DRIVE", so it rises
      // with the tx_nib update and drops on the first RELEASE cycle.
      tx_send_r     <= (next_state_s == DRIVE);

      if (next_state_s != state_r) begin
        cnt_r <= '0;
      end else if (((state_r == DRIVE) || (state_r == RELEASE)) && (cnt_r != '1)) begin
        cnt_r <= cnt_r + 1'b1;
      end else begin
        cnt_r <= cnt_r;
      end

      if ((state_r == IDLE) && (next_state_s == DRIVE)) begin
        shift_r  <= bus.in_data;
        idx_r    <= '0;
        tx_nib_r <= bus.in_data[3:0];
      end else if ((state_r == RELEASE) && (next_state_s == DRIVE)) begin
        shift_r  <= shifted_s;
        idx_r    <= idx_r + 1'b1;
        tx_nib_r <= shifted_s[3:0];
      end else begin
        shift_r  <= shift_r;
        idx_r    <= idx_r;
        tx_nib_r <= tx_nib_r;
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.busy        = busy_s;
  assign bus.done        = done_s;
  assign bus.tx_send     = tx_send_r;
  assign bus.tx_nib      = tx_nib_r;
  assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_nibble_tx.sv
// Scoreboard bench for nibble_tx: an 8-nibble instance with TIMEOUT=10 and a
// 2-nibble instance with the default timeout, each with its own receiver model.
module tb_nibble_tx;

  localparam int DN = 16;   // scoreboard code for a done pulse
  localparam int TE = 17;   // scoreboard code for a timeout_err pulse

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   qa[$];
  int   qb[$];
  int   mode_a;           // 0 ideal, 1 never ack nibble 2, 2 ack stuck high
  int   rxa_cnt;
  int   rxb_cnt;
  logic rxa_prev, rxb_prev;
  logic ma_send, ma_busy, mb_send, mb_busy;
  logic [3:0] ma_nib, mb_nib;

  nibble_tx_if #(.NIBBLES(8)) bus_a ();
  nibble_tx_if #(.NIBBLES(2)) bus_b ();

  nibble_tx #(.NIBBLES(8), .TIMEOUT(10)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  nibble_tx #(.NIBBLES(2))               u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_a(input string nm, input logic [31:0] got);
    logic [31:0] e;
    if (qa.size() == 0) e = 32'hDEAD;
    else e = qa.pop_front();
    check(nm, got, e);
  endtask

  task automatic pop_b(input string nm, input logic [31:0] got);
    logic [31:0] e;
    if (qb.size() == 0) e = 32'hDEAD;
    else e = qb.pop_front();
    check(nm, got, e);
  endtask

  // Receiver model A: acknowledge follows send half a cycle later, with fault modes.
  always @(negedge clk) begin
    if (bus_a.tx_send && !rxa_prev) rxa_cnt = rxa_cnt + 1;
    rxa_prev = bus_a.tx_send;
    if (mode_a == 2) bus_a.tx_ack = 1'b1;
    else if ((mode_a == 1) && (rxa_cnt == 3)) bus_a.tx_ack = 1'b0;
    else bus_a.tx_ack = bus_a.tx_send;
  end

  // Receiver model B: always ideal.
  always @(negedge clk) begin
    if (bus_b.tx_send && !rxb_prev) rxb_cnt = rxb_cnt + 1;
    rxb_prev = bus_b.tx_send;
    bus_b.tx_ack = bus_b.tx_send;
  end

  // Monitor A: pops the scoreboard on every send rise, done and timeout_err.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.tx_send && !ma_send) pop_a("a_nib", {28'd0, bus_a.tx_nib});
      if (bus_a.busy && ma_busy && (bus_a.tx_nib != ma_nib) && !(bus_a.tx_send && !ma_send))
        check("a_nib_stable", {28'd0, bus_a.tx_nib}, {28'd0, ma_nib});
      if (bus_a.done) pop_a("a_done", DN);
      if (bus_a.timeout_err) pop_a("a_toerr", TE);
      if (bus_a.done && bus_a.timeout_err) check("a_exclusive", 32'd1, 32'd0);
    end
    ma_send = bus_a.tx_send;
    ma_busy = bus_a.busy;
    ma_nib  = bus_a.tx_nib;
  end

  // Monitor B: same scheme for the 2-nibble instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_b.tx_send && !mb_send) pop_b("b_nib", {28'd0, bus_b.tx_nib});
      if (bus_b.busy && mb_busy && (bus_b.tx_nib != mb_nib) && !(bus_b.tx_send && !mb_send))
        check("b_nib_stable", {28'd0, bus_b.tx_nib}, {28'd0, mb_nib});
      if (bus_b.done) pop_b("b_done", DN);
      if (bus_b.timeout_err) pop_b("b_toerr", TE);
    end
    mb_send = bus_b.tx_send;
    mb_busy = bus_b.busy;
    mb_nib  = bus_b.tx_nib;
  end

  task automatic send_a(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus_a.in_ready && (n < 100)) begin
      @(negedge clk);
      n = n + 1;
    end
    check("a_ready_before_send", {31'd0, bus_a.in_ready}, 32'd1);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = w;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    check("a_busy_after_accept", {31'd0, bus_a.busy}, 32'd1);
  endtask

  // Waits for the end of a word on A: 1 = done, 2 = timeout_err.
  task automatic wait_a(output int kind);
    kind = 0;
    for (int i = 0; (i < 400) && (kind == 0); i++) begin
      @(negedge clk);
      if (bus_a.done) kind = 1;
      else if (bus_a.timeout_err) kind = 2;
    end
    if (kind == 0) check("a_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    int k;
    int t0;
    int found;
    int e_basic[9] = '{13, 12, 11, 10, 4, 3, 2, 1, DN};
    int e_abort[4] = '{15, 14, 13, TE};
    int e_next[9]  = '{15, 14, 13, 12, 11, 10, 9, 8, DN};
    int e_part[5]  = '{14, 11, 10, 11, 14};
    int e_five[9]  = '{5, 0, 0, 0, 0, 0, 0, 0, DN};

    n_checks = 0; n_fail = 0; cyc = 0; mode_a = 0; rxa_cnt = 0; rxb_cnt = 0;
    rxa_prev = 1'b0; rxb_prev = 1'b0;
    rst_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = 32'h0;
    bus_b.in_valid = 1'b0; bus_b.in_data = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_send", {31'd0, bus_a.tx_send}, 32'd0);
    check("rst_tx_nib", {28'd0, bus_a.tx_nib}, 32'd0);
    check("rst_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
    check("rst_busy", {31'd0, bus_a.busy}, 32'd0);
    check("rst_done", {31'd0, bus_a.done}, 32'd0);
    check("rst_timeout_err", {31'd0, bus_a.timeout_err}, 32'd0);
    check("rst_b_in_ready", {31'd0, bus_b.in_ready}, 32'd1);
    rst_n = 1'b1;

    // Basic transfer 0x1234ABCD.
    rxa_cnt = 0;
    foreach (e_basic[i]) qa.push_back(e_basic[i]);
    send_a(32'h1234ABCD);
    wait_a(k);
    check("basic_end_kind", k, 32'd1);
    check("basic_handshakes", rxa_cnt, 32'd8);
    @(negedge clk);
    check("basic_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
    check("basic_busy", {31'd0, bus_a.busy}, 32'd0);

    // Back-to-back: in_valid held with 0xFFFFFFFF then 0x00000000.
    for (int i = 0; i < 8; i++) qa.push_back(15);
    qa.push_back(DN);
    for (int i = 0; i < 8; i++) qa.push_back(0);
    qa.push_back(DN);
    @(negedge clk);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 32'hFFFFFFFF;
    @(negedge clk);
    bus_a.in_data  = 32'h00000000;
    wait_a(k);
    check("b2b_first_kind", k, 32'd1);
    check("b2b_finish_not_ready", {31'd0, bus_a.in_ready}, 32'd0);
    @(negedge clk);
    check("b2b_idle_ready", {31'd0, bus_a.in_ready}, 32'd1);
    check("b2b_idle_not_busy", {31'd0, bus_a.busy}, 32'd0);
    @(negedge clk);
    check("b2b_second_busy", {31'd0, bus_a.busy}, 32'd1);
    check("b2b_second_send", {31'd0, bus_a.tx_send}, 32'd1);
    bus_a.in_valid = 1'b0;
    wait_a(k);
    check("b2b_second_kind", k, 32'd1);

    // Timeout in DRIVE: receiver never acknowledges nibble 2.
    mode_a = 1; rxa_cnt = 0;
    foreach (e_abort[i]) qa.push_back(e_abort[i]);
    send_a(32'h9876CDEF);
    found = 0; t0 = 0;
    for (int i = 0; (i < 200) && (found == 0); i++) begin
      if (bus_a.tx_send && (bus_a.tx_nib == 4'hD)) begin
        found = 1;
        t0 = cyc;
      end else begin
        @(negedge clk);
      end
    end
    check("to_nib2_seen", found, 32'd1);
    wait_a(k);
    check("to_kind", k, 32'd2);
    check("to_latency", cyc - t0, 32'd10);
    check("to_tx_send", {31'd0, bus_a.tx_send}, 32'd0);
    check("to_idle", {31'd0, bus_a.in_ready}, 32'd1);
    check("to_busy", {31'd0, bus_a.busy}, 32'd0);
    @(negedge clk);
    check("to_pulse_once", {31'd0, bus_a.timeout_err}, 32'd0);
    mode_a = 0;

    // Stuck-high ack: nibble 0 times out waiting in RELEASE.
    mode_a = 2;
    repeat (3) @(negedge clk);
    qa.push_back(2);
    qa.push_back(TE);
    send_a(32'h11111112);
    t0 = cyc;
    wait_a(k);
    check("stuck_kind", k, 32'd2);
    check("stuck_latency", cyc - t0, 32'd11);
    mode_a = 0;
    repeat (3) @(negedge clk);
    foreach (e_next[i]) qa.push_back(e_next[i]);
    send_a(32'h89ABCDEF);
    wait_a(k);
    check("stuck_next_kind", k, 32'd1);

    // Reset during nibble 4, then a fresh word.
    rxa_cnt = 0;
    foreach (e_part[i]) qa.push_back(e_part[i]);
    send_a(32'hCAFEBABE);
    found = 0;
    for (int i = 0; (i < 200) && (found == 0); i++) begin
      @(negedge clk);
      if (rxa_cnt >= 5) found = 1;
    end
    check("mid_nib4_seen", found, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_tx_send", {31'd0, bus_a.tx_send}, 32'd0);
    check("mid_tx_nib", {28'd0, bus_a.tx_nib}, 32'd0);
    check("mid_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
    check("mid_busy", {31'd0, bus_a.busy}, 32'd0);
    check("mid_done", {31'd0, bus_a.done}, 32'd0);
    check("mid_timeout_err", {31'd0, bus_a.timeout_err}, 32'd0);
    check("mid_sb_drained", qa.size(), 32'd0);
    rst_n = 1'b1;
    foreach (e_five[i]) qa.push_back(e_five[i]);
    send_a(32'h00000005);
    wait_a(k);
    check("fresh_kind", k, 32'd1);

    // Two-nibble instance: 0xA5 sends 5 then A.
    rxb_cnt = 0;
    qb.push_back(5);
    qb.push_back(10);
    qb.push_back(DN);
    @(negedge clk);
    check("b_ready", {31'd0, bus_b.in_ready}, 32'd1);
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = 8'hA5;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    k = 0;
    for (int i = 0; (i < 200) && (k == 0); i++) begin
      @(negedge clk);
      if (bus_b.done) k = 1;
      else if (bus_b.timeout_err) k = 2;
    end
    check("b_end_kind", k, 32'd1);
    check("b_handshakes", rxb_cnt, 32'd2);
    @(negedge clk);
    check("b_ready_after", {31'd0, bus_b.in_ready}, 32'd1);

    repeat (4) @(negedge clk);
    check("a_sb_empty", qa.size(), 32'd0);
    check("b_sb_empty", qb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
